data_sram_seq: RTL and testbench

Sequencer between the MEM pipeline stage and a variable-latency data SRAM. Accepts one load or store per pipeline request, generates byte enables, write-data replication and address alignment, holds the pipeline via `stallreq` until the SRAM acknowledges, and returns sign- or zero-extended load data. It sits beside MEM; its `stallreq` feeds the stall controller that produces the `stall` bus.

---
 rtl/data_sram_seq_pkg.sv | 16 +
 rtl/data_sram_seq_lane_align.sv | 23 ++
 rtl/data_sram_seq.sv | 86 ++++++++
 tb/tb_data_sram_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_seq_pkg.sv
// data_sram_seq_pkg: size codes, FSM states and alignment helpers for the data SRAM sequencer
package data_sram_seq_pkg;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_e;
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return size == 2'b11 ? SIZE_W : size;
    endfunction
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SIZE_H && off[0]) || (size == SIZE_W && off != 2'b00);
    endfunction
    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_B ? off : size == SIZE_H ? {off[1], 1'b0} : 2'b00;
    endfunction
endpackage

// File: rtl/data_sram_seq_lane_align.sv
// data_sram_seq_lane_align: byte-enable and store-data lane replication, load lane select and extension
module data_sram_seq_lane_align
    import data_sram_seq_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata_i[{off_i, 3'b000} +: 8];
        h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wen_o = size_i == SIZE_B ? 4'b0001 << off_i : size_i == SIZE_H ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = size_i == SIZE_B ? {4{wdata_i[7:0]}} : size_i == SIZE_H ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = size_i == SIZE_B ? {{24{sign_i & b[7]}}, b} : size_i == SIZE_H ? {{16{sign_i & h[15]}}, h} : rdata_i;
    end
endmodule

// File: rtl/data_sram_seq.sv
// data_sram_seq: MEM-stage data SRAM sequencer; define DATA_SRAM_ALIGN_CHECK_EN to trap misaligned accesses
module data_sram_seq
    import data_sram_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              data_sram_ready,
    input  logic [31:0]       data_sram_rdata,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    output logic              stallreq,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              exc_ale
);
    state_e            state_q, state_d;
    logic              we_q, sign_q;
    logic [1:0]        size_q, size_n, off_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, rdata_d;
    logic              mis, accept, done_acc;
    logic [3:0]        lane_wen;
    logic [31:0]       lane_wdata, lane_rdata;
    assign size_n = norm_size(req_size);
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    assign mis = misaligned(size_n, req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign off_n = force_align(size_n, req_addr[1:0]);
    assign accept = state_q == IDLE && req_valid && !mis;
    assign done_acc = state_q == ACCESS && data_sram_ready;
    data_sram_seq_lane_align u_lane (
        .size_i  (size_q),
        .off_i   (addr_q[1:0]),
        .sign_i  (sign_q),
        .wdata_i (wdata_q),
        .rdata_i (data_sram_rdata),
        .wen_o   (lane_wen),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );
    always_comb begin
        state_d = accept ? ACCESS : done_acc ? DONE : state_q == DONE ? IDLE : state_q;
        rdata_d = done_acc ? (we_q ? 32'd0 : lane_rdata) : rdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= req_we;
                sign_q  <= req_sign;
                size_q  <= size_n;
                addr_q  <= {req_addr[ADDR_W-1:2], off_n};
                wdata_q <= req_wdata;
            end
        end
    end
    assign data_sram_en    = state_q == ACCESS;
    assign data_sram_wen   = data_sram_en && we_q ? lane_wen : 4'b0000;
    assign data_sram_addr  = data_sram_en ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign data_sram_wdata = data_sram_en && we_q ? lane_wdata : 32'd0;
    assign stallreq        = accept || state_q == ACCESS;
    assign resp_valid      = state_q == DONE;
    assign resp_rdata      = state_q == DONE ? rdata_q : 32'd0;
    assign exc_ale         = state_q == IDLE && req_valid && mis;
endmodule

// File: tb/tb_data_sram_seq.sv
// tb_data_sram_seq: directed bench with a transaction-level model checked every cycle plus literal pins
module tb_data_sram_seq;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        data_sram_ready = 1'b0;
    logic [31:0] data_sram_rdata = 32'd0;
    logic        data_sram_en, stallreq, resp_valid, exc_ale;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, resp_rdata;
    always #5 clk = ~clk;
    data_sram_seq #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .data_sram_ready(data_sram_ready), .data_sram_rdata(data_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .stallreq(stallreq), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .exc_ale(exc_ale)
    );
    int checks = 0, failures = 0;
    logic e_en = 0, e_stall = 0, e_resp = 0, e_exc = 0, e_store = 0, full_chk = 0;
    logic [3:0] e_wen = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
    int n_en = 0, n_stall = 0, n_resp = 0, n_exc = 0, n_acc = 0;
    logic prev_en = 0;
    logic [3:0] last_wen = 0;
    logic [31:0] last_addr = 0, last_wdata = 0, last_rdata = 0;
    int b_en, b_stall, b_resp, b_exc, b_acc;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [3:0] m_wen(input logic we, input logic [1:0] sz, input logic [1:0] off);
        if (!we) return 4'd0;
        return sz == 2'd0 ? 4'(1 << off) : sz == 2'd1 ? 4'(3 << off) : 4'd15;
    endfunction
    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        return sz == 2'd0 ? (wd & 32'hFF) * 32'h01010101 : sz == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    endfunction
    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz, input logic sg, input logic [1:0] off);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction
    task automatic tick();
        @(negedge clk);
        chk("en", {31'd0, data_sram_en}, {31'd0, e_en});
        chk("stallreq", {31'd0, stallreq}, {31'd0, e_stall});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_resp});
        chk("exc_ale", {31'd0, exc_ale}, {31'd0, e_exc});
        if (e_en || full_chk) begin
            chk("addr", data_sram_addr, e_addr);
            chk("wen", {28'd0, data_sram_wen}, {28'd0, e_wen});
        end
        if ((e_en && e_store) || full_chk) chk("wdata", data_sram_wdata, e_wdata);
        if (e_resp || full_chk) chk("resp_rdata", resp_rdata, e_rdata);
        n_en += int'(data_sram_en);
        n_stall += int'(stallreq);
        n_resp += int'(resp_valid);
        n_exc += int'(exc_ale);
        if (data_sram_en && !prev_en) n_acc++;
        prev_en = data_sram_en;
        if (data_sram_en) begin
            last_wen = data_sram_wen;
            last_addr = data_sram_addr;
            last_wdata = data_sram_wdata;
        end
        if (resp_valid) last_rdata = resp_rdata;
        @(posedge clk);
        #1;
    endtask
    task automatic set_idle();
        req_valid = 0;
        data_sram_ready = 0;
        e_en = 0; e_stall = 0; e_resp = 0; e_exc = 0; e_store = 0; full_chk = 0;
        e_wen = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
    endtask
    task automatic snap();
        b_en = n_en; b_stall = n_stall; b_resp = n_resp; b_exc = n_exc; b_acc = n_acc;
    endtask
    task automatic access(input logic we, input logic [1:0] size, input logic sign, input logic [31:0] addr,
                          input logic [31:0] wd, input int k, input logic [31:0] rd);
        logic [1:0] sz, off;
        logic mis;
        sz = size[1] ? 2'd2 : size;
`ifdef DATA_SRAM_ALIGN_CHECK_EN
        mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
`else
        mis = 1'b0;
`endif
        off = sz == 2'd0 ? addr[1:0] : sz == 2'd1 ? (addr[1:0] & 2'b10) : 2'b00;
        req_valid = 1; req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wd;
        data_sram_ready = 1; data_sram_rdata = 32'h5A5A5A5A;
        e_en = 0; e_stall = !mis; e_exc = mis; e_resp = 0; full_chk = 0; e_store = we;
        tick();
        if (mis) begin
            set_idle();
            return;
        end
        e_exc = 0; e_en = 1; e_stall = 1;
        e_wen = m_wen(we, sz, off);
        e_addr = {addr[31:2], 2'b00};
        e_wdata = m_wdata(sz, wd);
        for (int j = 0; j <= k; j++) begin
            data_sram_ready = (j == k);
            data_sram_rdata = (j == k) ? rd : ~rd;
            tick();
        end
        e_en = 0; e_stall = 0; e_resp = 1;
        e_rdata = we ? 32'd0 : m_load(rd, sz, sign, off);
        data_sram_ready = 1; data_sram_rdata = 32'hFFFF0000;
        tick();
        e_resp = 0;
    endtask
    initial begin
        @(posedge clk);
        #1;
        set_idle();
        full_chk = 1;
        tick();
        rst = 0;
        tick();
        full_chk = 0;
        snap();
        access(1, 2'b10, 0, 32'h100, 32'h12345678, 2, 32'h0);
        set_idle(); tick();
        chk("w_store_en_cycles", n_en - b_en, 3);
        chk("w_store_stall_cycles", n_stall - b_stall, 4);
        chk("w_store_resp", n_resp - b_resp, 1);
        chk("w_store_wen", {28'd0, last_wen}, 32'hF);
        chk("w_store_addr", last_addr, 32'h100);
        chk("w_store_wdata", last_wdata, 32'h12345678);
        access(0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h80FFFFFF);
        set_idle(); tick();
        chk("lb_signed", last_rdata, 32'hFFFFFF80);
        access(0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80FFFFFF);
        set_idle(); tick();
        chk("lbu", last_rdata, 32'h00000080);
        access(1, 2'b01, 0, 32'h102, 32'h0000ABCD, 1, 32'h0);
        set_idle(); tick();
        chk("sh_wen", {28'd0, last_wen}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        snap();
        access(0, 2'b10, 0, 32'h101, 32'h0, 0, 32'hCAFEF00D);
        set_idle(); tick();
`ifdef DATA_SRAM_ALIGN_CHECK_EN
        chk("ale_pulses", n_exc - b_exc, 1);
        chk("ale_no_en", n_en - b_en, 0);
        chk("ale_no_stall", n_stall - b_stall, 0);
`else
        chk("unaligned_addr", last_addr, 32'h100);
        chk("unaligned_en", n_en - b_en, 1);
        chk("unaligned_rdata", last_rdata, 32'hCAFEF00D);
        chk("unaligned_no_ale", n_exc - b_exc, 0);
`endif
        snap();
        req_valid = 1; req_we = 0; req_size = 2'b10; req_sign = 0; req_addr = 32'h200;
        data_sram_ready = 0; e_stall = 1;
        tick();
        e_en = 1; e_wen = 0; e_addr = 32'h200; rst = 1;
        tick();
        rst = 0;
        set_idle();
        full_chk = 1;
        tick();
        data_sram_ready = 1; data_sram_rdata = 32'h11111111;
        tick();
        data_sram_ready = 0;
        tick(); tick();
        full_chk = 0;
        chk("rst_no_resp", n_resp - b_resp, 0);
        chk("rst_one_access_cycle", n_en - b_en, 1);
        snap();
        access(0, 2'b01, 1, 32'h106, 32'h0, 1, 32'h80017FFF);
        access(0, 2'b00, 0, 32'h105, 32'h0, 0, 32'h0000AB00);
        set_idle(); tick();
        chk("b2b_accesses", n_acc - b_acc, 2);
        chk("b2b_resps", n_resp - b_resp, 2);
        chk("b2b_last_rdata", last_rdata, 32'h000000AB);
        for (int s = 0; s < 4; s++)
            for (int o = 0; o < 4; o++)
                for (int w = 0; w < 2; w++) begin
                    access(w[0], s[1:0], o[0] ^ w[0], 32'h300 + o, 32'hC3A59F81, o % 3, 32'h8899F17E);
                    set_idle(); tick();
                end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
